// File: rtl/reu_dma_sequencer.sv
// reu_dma_sequencer: REU register file plus byte-transfer sequencer; swap/verify built only when REU_SWAP_VERIFY_EN is defined
module reu_dma_sequencer #(
    parameter int          RAM_A_BITS   = 17,
    parameter logic [3:0]  VERSION      = 4'h8,
    parameter logic [23:0] DEF_RAM_ADDR = 24'hf80000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            a,
    input  logic [7:0]            d_d,
    output logic [7:0]            d_q,
    input  logic                  read_strobe,
    input  logic                  write_strobe,
    input  logic                  ff00_strobe,
    output logic [15:0]           dma_a,
    output logic [7:0]            dma_d,
    input  logic [7:0]            dma_q,
    output logic                  dma_rw,
    output logic                  dma_req,
    input  logic                  dma_ack,
    output logic [RAM_A_BITS-1:0] ram_a,
    output logic [7:0]            ram_d,
    input  logic [7:0]            ram_q,
    output logic                  ram_we,
    output logic                  ram_req,
    input  logic                  ram_ack,
    output logic                  busy,
    output logic                  irq
);
    typedef enum logic [3:0] {IDLE, ARMED, C64_RD, RAM_RD, RAM_WR, C64_WR, COMPARE, STEP, DONE} state_t;
    state_t state, st_idle, st_arm;
    logic [15:0] c64_addr, c64_shadow, c64_next, tcnt, tcnt_shadow;
    logic [RAM_A_BITS-1:0] ram_addr, ram_shadow, ram_next;
    logic [23:0] ram_full, ram_wr;
    logic [7:0] lat_a, lat_b, rd_data;
    logic [3:0] idx;
    logic [1:0] ttype;
    logic execute, autoload, ff00, irq_enable, im_eob, im_fault, fix_c64, fix_ram, eob, fault, wr, pend;

    function automatic state_t first_of(input logic [1:0] t);
`ifdef REU_SWAP_VERIFY_EN
        return t == 2'd1 ? RAM_RD : C64_RD;
`else
        return t == 2'd1 ? RAM_RD : t == 2'd0 ? C64_RD : DONE;
`endif
    endfunction

    assign idx      = a[3:0];
    assign wr       = write_strobe && (state == IDLE || state == ARMED);
    assign pend     = (eob & im_eob) | (fault & im_fault);
    assign irq      = pend & irq_enable;
    assign busy     = state != IDLE;
    assign c64_next = fix_c64 ? c64_addr : c64_addr + 16'd1;
    assign ram_next = fix_ram ? ram_addr : ram_addr + RAM_A_BITS'(1);
    assign st_idle  = first_of(d_d[1:0]);
    assign st_arm   = first_of(ttype);

    // full 24-bit RAM address view and its byte-merged update for register writes
    always_comb begin
        ram_full = DEF_RAM_ADDR;
        ram_full[RAM_A_BITS-1:0] = ram_addr;
        ram_wr = ram_full;
        if (idx == 4'h4) ram_wr[7:0] = d_d;
        if (idx == 4'h5) ram_wr[15:8] = d_d;
        if (idx == 4'h6) ram_wr[23:16] = d_d;
    end

    // register read multiplexer
    always_comb begin
        case (idx)
            4'h0:    rd_data = {pend, eob, fault, 1'(RAM_A_BITS >= 19), VERSION};
            4'h1:    rd_data = {execute, 1'b0, autoload, ff00, 2'b00, ttype};
            4'h2:    rd_data = c64_addr[7:0];
            4'h3:    rd_data = c64_addr[15:8];
            4'h4:    rd_data = ram_full[7:0];
            4'h5:    rd_data = ram_full[15:8];
            4'h6:    rd_data = ram_full[23:16];
            4'h7:    rd_data = tcnt[7:0];
            4'h8:    rd_data = tcnt[15:8];
            4'h9:    rd_data = {irq_enable, im_eob, im_fault, 5'h1f};
            4'ha:    rd_data = {fix_c64, fix_ram, 6'h3f};
            default: rd_data = 8'hff;
        endcase
    end

    // registered CPU read data
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) d_q <= 8'hff;
        else if (read_strobe) d_q <= rd_data;

    // register file and transfer sequencer; later flag sets override an earlier read-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            {execute, autoload, irq_enable, im_eob, im_fault, fix_c64, fix_ram, eob, fault} <= '0;
            ff00 <= 1'b1;
            ttype <= 2'd0;
            c64_addr <= '0;
            c64_shadow <= '0;
            ram_addr <= DEF_RAM_ADDR[RAM_A_BITS-1:0];
            ram_shadow <= DEF_RAM_ADDR[RAM_A_BITS-1:0];
            tcnt <= 16'hffff;
            tcnt_shadow <= 16'hffff;
            {lat_a, lat_b, dma_d, ram_d} <= '0;
            dma_a <= '0;
            ram_a <= '0;
            {dma_rw, dma_req, ram_we, ram_req} <= '0;
        end else begin
            if (read_strobe && idx == 4'h0) {eob, fault} <= 2'b00;
            if (wr)
                case (idx)
                    4'h1: {execute, autoload, ff00, ttype} <= {d_d[7], d_d[5], d_d[4], d_d[1:0]};
                    4'h2: {c64_addr[7:0], c64_shadow[7:0]} <= {d_d, d_d};
                    4'h3: {c64_addr[15:8], c64_shadow[15:8]} <= {d_d, d_d};
                    4'h4, 4'h5, 4'h6: {ram_addr, ram_shadow} <= {ram_wr[RAM_A_BITS-1:0], ram_wr[RAM_A_BITS-1:0]};
                    4'h7: {tcnt[7:0], tcnt_shadow[7:0]} <= {d_d, d_d};
                    4'h8: {tcnt[15:8], tcnt_shadow[15:8]} <= {d_d, d_d};
                    4'h9: {irq_enable, im_eob, im_fault} <= d_d[7:5];
                    4'ha: {fix_c64, fix_ram} <= d_d[7:6];
                    default: ;
                endcase
            case (state)
                IDLE:
                    if (wr && idx == 4'h1 && d_d[7]) begin
                        state <= d_d[4] ? st_idle : ARMED;
                        if (d_d[4] && st_idle == DONE) eob <= 1'b1;
                    end
                ARMED:
                    if (wr && idx == 4'h1 && !d_d[7]) state <= IDLE;
                    else if (ff00_strobe) begin
                        state <= st_arm;
                        if (st_arm == DONE) eob <= 1'b1;
                    end
                C64_RD:
                    if (!dma_req) {dma_req, dma_rw, dma_a} <= {1'b1, 1'b1, c64_addr};
                    else if (dma_ack) begin
                        dma_req <= 1'b0;
                        lat_a <= dma_q;
                        state <= ttype == 2'd0 ? RAM_WR : RAM_RD;
                    end
                RAM_RD:
                    if (!ram_req) {ram_req, ram_we, ram_a} <= {1'b1, 1'b0, ram_addr};
                    else if (ram_ack) begin
                        ram_req <= 1'b0;
                        lat_b <= ram_q;
                        state <= ttype == 2'd1 ? C64_WR : ttype == 2'd2 ? RAM_WR : COMPARE;
                    end
                RAM_WR:
                    if (!ram_req) {ram_req, ram_we, ram_a, ram_d} <= {1'b1, 1'b1, ram_addr, lat_a};
                    else if (ram_ack) begin
                        {ram_req, ram_we} <= 2'b00;
                        state <= ttype == 2'd2 ? C64_WR : STEP;
                    end
                C64_WR:
                    if (!dma_req) {dma_req, dma_rw, dma_a, dma_d} <= {1'b1, 1'b0, c64_addr, lat_b};
                    else if (dma_ack) begin
                        dma_req <= 1'b0;
                        state <= STEP;
                    end
`ifdef REU_SWAP_VERIFY_EN
                COMPARE:
                    if (lat_a != lat_b) begin
                        fault <= 1'b1;
                        if (tcnt == 16'd1) eob <= 1'b1;
                        c64_addr <= c64_next;
                        ram_addr <= ram_next;
                        state <= DONE;
                    end else state <= STEP;
`endif
                STEP: begin
                    c64_addr <= c64_next;
                    ram_addr <= ram_next;
                    if (tcnt == 16'd1) begin
                        eob <= 1'b1;
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt - 16'd1;
                        state <= st_arm;
                    end
                end
                DONE: begin
                    execute <= 1'b0;
                    ff00 <= 1'b1;
                    if (autoload) {c64_addr, ram_addr, tcnt} <= {c64_shadow, ram_shadow, tcnt_shadow};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reu_dma_sequencer.sv
// tb_reu_dma_sequencer: table vectors, directed corner cases and randomized transfers against a transfer-level model
module tb_reu_dma_sequencer;
`ifdef REU_SWAP_VERIFY_EN
    localparam bit SV = 1'b1;
`else
    localparam bit SV = 1'b0;
`endif
    logic clk = 1'b0, reset_n = 1'b0;
    logic [7:0] a = '0, d_d = '0, d_q, dma_d, dma_q, ram_d, ram_q;
    logic read_strobe = 1'b0, write_strobe = 1'b0, ff00_strobe = 1'b0;
    logic [15:0] dma_a;
    logic [16:0] ram_a;
    logic dma_rw, dma_req, dma_ack, ram_we, ram_req, ram_ack, busy, irq;

    logic [7:0] c64_mem [65536];
    logic [7:0] ram_mem [131072];
    logic [7:0] exp_c64 [65536];
    logic [7:0] exp_ram [131072];
    logic [16:0] ram_wlog [$];
    string req_str = "";
    int overlap = 0, checks = 0, errors = 0;

    typedef struct { logic [3:0] idx; logic [7:0] w; logic [7:0] exp; } vec_t;
    vec_t tbl [13];
    logic [7:0] rst_exp [16];

    always #5 clk = ~clk;

    reu_dma_sequencer dut (
        .clk(clk), .reset_n(reset_n), .a(a), .d_d(d_d), .d_q(d_q),
        .read_strobe(read_strobe), .write_strobe(write_strobe), .ff00_strobe(ff00_strobe),
        .dma_a(dma_a), .dma_d(dma_d), .dma_q(dma_q), .dma_rw(dma_rw), .dma_req(dma_req), .dma_ack(dma_ack),
        .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q), .ram_we(ram_we), .ram_req(ram_req), .ram_ack(ram_ack),
        .busy(busy), .irq(irq)
    );

    // bus slaves with random latency; data moves in the ack cycle
    initial begin
        dma_ack = 1'b0; ram_ack = 1'b0; dma_q = '0; ram_q = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dma_req && ram_req) overlap++;
            if (dma_ack) dma_ack = 1'b0;
            else if (dma_req && $urandom_range(0, 2) != 0) begin
                dma_ack = 1'b1;
                if (dma_rw) dma_q = c64_mem[dma_a]; else c64_mem[dma_a] = dma_d;
                req_str = {req_str, "d"};
            end
            if (ram_ack) ram_ack = 1'b0;
            else if (ram_req && $urandom_range(0, 2) != 0) begin
                ram_ack = 1'b1;
                if (ram_we) begin ram_mem[ram_a] = ram_d; ram_wlog.push_back(ram_a); end
                else ram_q = ram_mem[ram_a];
                req_str = {req_str, "r"};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] i, input logic [7:0] v);
        a = {4'h0, i}; d_d = v; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] i, output logic [7:0] v);
        a = {4'h0, i}; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        v = d_q;
    endtask

    task automatic rd_regs(output logic [15:0] c, output logic [23:0] r, output logic [15:0] t);
        logic [7:0] b [9];
        for (int i = 2; i <= 8; i++) rd_reg(4'(i), b[i]);
        c = {b[3], b[2]}; r = {b[6], b[5], b[4]}; t = {b[8], b[7]};
    endtask

    task automatic set_regs(input logic [15:0] c, input logic [16:0] r, input logic [15:0] t, input logic fc, input logic fr);
        wr_reg(4'h2, c[7:0]); wr_reg(4'h3, c[15:8]);
        wr_reg(4'h4, r[7:0]); wr_reg(4'h5, r[15:8]); wr_reg(4'h6, {7'h0, r[16]});
        wr_reg(4'h7, t[7:0]); wr_reg(4'h8, t[15:8]);
        wr_reg(4'ha, {fc, fr, 6'h0});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        chk(name, busy, 0);
    endtask

    task automatic mem_check(input string name);
        int dc = 0, dr = 0;
        for (int i = 0; i < 65536; i++) if (c64_mem[i] !== exp_c64[i]) dc++;
        for (int i = 0; i < 131072; i++) if (ram_mem[i] !== exp_ram[i]) dr++;
        chk({name, " c64 diffs"}, dc, 0);
        chk({name, " ram diffs"}, dr, 0);
    endtask

    // whole-transfer outcome from the register-level rules, applied to exp_c64/exp_ram
    task automatic model(input logic [1:0] tt, input logic [15:0] c, input logic [16:0] r, input logic [15:0] t,
                         input logic fc, input logic fr, input logic al,
                         output logic [15:0] cf, output logic [16:0] rf, output logic [15:0] tf, output logic eb, output logic ft);
        int n, k;
        logic [15:0] ca;
        logic [16:0] ra;
        logic [7:0] tmp;
        n = t == 0 ? 65536 : int'(t);
        k = n;
        ft = 1'b0;
        if (!SV && tt[1]) begin
            cf = c; rf = r; tf = t; eb = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                ca = 16'(c + (fc ? 0 : i));
                ra = 17'(r + (fr ? 0 : i));
                if (tt == 0) exp_ram[ra] = exp_c64[ca];
                else if (tt == 1) exp_c64[ca] = exp_ram[ra];
                else if (tt == 2) begin tmp = exp_ram[ra]; exp_ram[ra] = exp_c64[ca]; exp_c64[ca] = tmp; end
                else if (exp_c64[ca] != exp_ram[ra]) begin ft = 1'b1; k = i + 1; break; end
            end
            cf = 16'(c + (fc ? 0 : k));
            rf = 17'(r + (fr ? 0 : k));
            tf = ft ? 16'(n - k + 1) : 16'd1;
            eb = !ft || (n - k + 1 == 1);
        end
        if (al) begin cf = c; rf = r; tf = t; end
    endtask

    initial begin
        logic [7:0] v;
        logic [15:0] c, cf, t, tf;
        logic [23:0] r;
        logic [16:0] rf;
        logic eb, ft, ok;
        rst_exp = '{8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'hf8, 8'hff,
                    8'hff, 8'h1f, 8'h3f, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};
        tbl[0]  = '{4'h2, 8'h34, 8'h34};
        tbl[1]  = '{4'h3, 8'h12, 8'h12};
        tbl[2]  = '{4'h4, 8'h5a, 8'h5a};
        tbl[3]  = '{4'h5, 8'hc3, 8'hc3};
        tbl[4]  = '{4'h6, 8'hab, 8'hf9};
        tbl[5]  = '{4'h7, 8'h00, 8'h00};
        tbl[6]  = '{4'h8, 8'h80, 8'h80};
        tbl[7]  = '{4'h9, 8'he0, 8'hff};
        tbl[8]  = '{4'h9, 8'h40, 8'h5f};
        tbl[9]  = '{4'ha, 8'h80, 8'hbf};
        tbl[10] = '{4'h1, 8'h23, 8'h23};
        tbl[11] = '{4'h0, 8'hff, 8'h08};
        tbl[12] = '{4'hb, 8'h00, 8'hff};
        for (int i = 0; i < 65536; i++) c64_mem[i] = 8'($urandom);
        for (int i = 0; i < 131072; i++) ram_mem[i] = 8'($urandom);

        do_reset();
        chk("reset outputs", {busy, irq, dma_req, ram_req, dma_rw, ram_we, d_q}, {6'b0, 8'hff});
        for (int i = 0; i < 16; i++) begin rd_reg(4'(i), v); chk($sformatf("reset reg%0h", i), v, rst_exp[i]); end
        for (int i = 0; i < 13; i++) begin
            wr_reg(tbl[i].idx, tbl[i].w);
            rd_reg(tbl[i].idx, v);
            chk($sformatf("regwr %0d reg%0h", i, tbl[i].idx), v, tbl[i].exp);
        end

        // stash of four bytes
        do_reset();
        for (int i = 0; i < 4; i++) c64_mem[16'h1000 + i] = 8'(8'h11 * (i + 1));
        set_regs(16'h1000, 17'h100, 16'd4, 1'b0, 1'b0);
        req_str = "";
        wr_reg(4'h1, 8'h90);
        wait_idle("stash idle");
        chk("stash ram", {ram_mem[17'h100], ram_mem[17'h101], ram_mem[17'h102], ram_mem[17'h103]}, 32'h11223344);
        chk_s("stash order", req_str, "drdrdrdr");
        rd_regs(c, r, t);
        chk("stash regs", {c, r, t}, {16'h1004, 24'hf80104, 16'h0001});
        rd_reg(4'h0, v); chk("stash reg0", v, 8'h48);
        rd_reg(4'h0, v); chk("stash reg0 cleared", v, 8'h08);

        // fetch armed by ff00
        do_reset();
        for (int i = 0; i < 3; i++) ram_mem[17'h200 + i] = 8'(8'ha0 + i);
        set_regs(16'h3000, 17'h200, 16'd3, 1'b0, 1'b0);
        wr_reg(4'h1, 8'h81);
        ok = 1'b1;
        repeat (4) begin ok &= busy & ~dma_req & ~ram_req; @(negedge clk); end
        chk("armed waits", ok, 1);
        wr_reg(4'h1, 8'h01);
        chk("armed cancel", busy, 0);
        wr_reg(4'h1, 8'h81);
        ff00_strobe = 1'b1; @(negedge clk); ff00_strobe = 1'b0;
        wait_idle("fetch idle");
        chk("fetch c64", {c64_mem[16'h3000], c64_mem[16'h3001], c64_mem[16'h3002]}, 24'ha0a1a2);
        rd_reg(4'h1, v); chk("fetch reg1", v, 8'h11);

`ifdef REU_SWAP_VERIFY_EN
        do_reset();
        c64_mem[16'h2000] = 8'haa; ram_mem[0] = 8'h55;
        set_regs(16'h2000, 17'h0, 16'd1, 1'b0, 1'b0);
        req_str = "";
        wr_reg(4'h1, 8'h92);
        wait_idle("swap idle");
        chk("swap data", {c64_mem[16'h2000], ram_mem[0]}, 16'h55aa);
        chk_s("swap order", req_str, "drrd");

        do_reset();
        for (int i = 0; i < 3; i++) begin c64_mem[16'h4000 + i] = 8'(i + 1); ram_mem[17'h10 + i] = 8'(i + 1); end
        ram_mem[17'h11] = 8'hff;
        set_regs(16'h4000, 17'h10, 16'd3, 1'b0, 1'b0);
        wr_reg(4'h9, 8'ha0);
        wr_reg(4'h1, 8'h93);
        wait_idle("verify idle");
        chk("verify irq", irq, 1);
        rd_regs(c, r, t);
        chk("verify regs", {c, r, t}, {16'h4002, 24'hf80012, 16'h0002});
        rd_reg(4'h0, v); chk("verify reg0", v, 8'ha8);
        chk("verify irq cleared", irq, 0);
        rd_reg(4'h0, v); chk("verify reg0 cleared", v, 8'h08);
`else
        do_reset();
        c64_mem[16'h2000] = 8'haa; ram_mem[0] = 8'h55;
        set_regs(16'h2000, 17'h0, 16'd1, 1'b0, 1'b0);
        req_str = "";
        wr_reg(4'h1, 8'h92);
        wait_idle("swap-off idle");
        chk_s("swap-off no bus", req_str, "");
        chk("swap-off data", {c64_mem[16'h2000], ram_mem[0]}, 16'haa55);
        rd_regs(c, r, t);
        chk("swap-off regs", {c, r, t}, {16'h2000, 24'hf80000, 16'h0001});
        rd_reg(4'h0, v); chk("swap-off reg0", v, 8'h48);
`endif

        // RAM address wrap, fixed C64 address, autoload
        do_reset();
        c64_mem[16'hffff] = 8'h5a; ram_mem[17'h1ffff] = 8'h00; ram_mem[0] = 8'h00;
        set_regs(16'hffff, 17'h1ffff, 16'd2, 1'b1, 1'b0);
        ram_wlog.delete();
        wr_reg(4'h1, 8'hb0);
        wait_idle("wrap idle");
        chk("wrap data", {ram_mem[17'h1ffff], ram_mem[0]}, 16'h5a5a);
        chk("wrap wr count", ram_wlog.size(), 2);
        chk("wrap wr addrs", {ram_wlog[0], ram_wlog[1]}, {17'h1ffff, 17'h0});
        rd_regs(c, r, t);
        chk("wrap autoload regs", {c, r, t}, {16'hffff, 24'hf9ffff, 16'h0002});
        rd_reg(4'h1, v); chk("wrap reg1", v, 8'h30);

        // randomized transfers against the model
        do_reset();
        for (int it = 0; it < 12; it++) begin
            logic [1:0] tt;
            logic [15:0] ca, tn;
            logic [16:0] ra;
            logic fc, fr, al, f0;
            int kbad;
            tt = 2'($urandom_range(0, 3));
            ca = 16'($urandom); ra = 17'($urandom); tn = 16'($urandom_range(1, 6));
            fc = $urandom_range(0, 3) == 0; fr = $urandom_range(0, 3) == 0;
            al = 1'($urandom); f0 = 1'($urandom);
            if (tt == 3) begin
                for (int i = 0; i < tn; i++) ram_mem[17'(ra + (fr ? 0 : i))] = c64_mem[16'(ca + (fc ? 0 : i))];
                kbad = $urandom_range(0, int'(tn));
                if (kbad < tn) ram_mem[17'(ra + (fr ? 0 : kbad))] = ~ram_mem[17'(ra + (fr ? 0 : kbad))];
            end
            exp_c64 = c64_mem; exp_ram = ram_mem;
            model(tt, ca, ra, tn, fc, fr, al, cf, rf, tf, eb, ft);
            wr_reg(4'h9, 8'h00);
            set_regs(ca, ra, tn, fc, fr);
            wr_reg(4'h1, {1'b1, 1'b0, al, f0, 2'b00, tt});
            if (!f0) begin
                repeat (2) @(negedge clk);
                ff00_strobe = 1'b1; @(negedge clk); ff00_strobe = 1'b0;
            end
            wait_idle($sformatf("rand%0d idle", it));
            mem_check($sformatf("rand%0d", it));
            rd_regs(c, r, t);
            chk($sformatf("rand%0d regs tt%0d", it, tt), {c, r, t}, {cf, 7'h7c, rf, tf});
            rd_reg(4'h0, v);
            chk($sformatf("rand%0d reg0", it), v, {1'b0, eb, ft, 1'b0, 4'h8});
        end

        // reset in the middle of a RAM write
        do_reset();
        set_regs(16'h5000, 17'h300, 16'd4, 1'b0, 1'b0);
        wr_reg(4'h1, 8'h90);
        begin
            int n = 0;
            while (!ram_req && n < 200) begin @(negedge clk); n++; end
        end
        chk("mid ram_wr reached", {ram_req, ram_we}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk("mid reset drops", {ram_req, dma_req, busy}, 3'b000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin rd_reg(4'(i), v); chk($sformatf("post reset reg%0h", i), v, rst_exp[i]); end
        chk("post reset busy", busy, 0);
        chk("one req at a time", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
